// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider plus 640x480 raster counters with registered sync/blank decode.
`timescale 1ns/1ps
module vga_sync_gen #(
   parameter int HD = 640,
   parameter int HF = 16,
   parameter int HR = 96,
   parameter int HB = 48,
   parameter int VD = 480,
   parameter int VF = 10,
   parameter int VR = 2,
   parameter int VB = 33,
   parameter int DIV = 4,
   parameter bit SYNC_ACT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);
   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;
   localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
   if (HT > 1024 || VT > 1024 || DIV < 1) begin : g_bad_params
      $error("vga_sync_gen: HT/VT must fit 10-bit counters and DIV must be >= 1");
   end
   logic [DW-1:0] div_cnt;
   logic [9:0] x_next, y_next;
   logic x_wrap, y_wrap;
   assign p_tick = div_cnt == DW'(DIV - 1);
   assign x_wrap = pixel_x == 10'(HT - 1);
   assign y_wrap = pixel_y == 10'(VT - 1);
   assign x_next = x_wrap ? 10'd0 : pixel_x + 10'd1;
   assign y_next = x_wrap ? (y_wrap ? 10'd0 : pixel_y + 10'd1) : pixel_y;
   // Decodes use next-state counters so they land on the same edge as pixel_x/pixel_y.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt     <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         video_on    <= 1'b0;
         hsync       <= ~SYNC_ACT;
         vsync       <= ~SYNC_ACT;
         frame_start <= 1'b0;
      end else begin
         div_cnt <= p_tick ? '0 : div_cnt + 1'b1;
         if (p_tick) begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            video_on    <= (x_next < 10'(HD)) && (y_next < 10'(VD));
            hsync       <= (x_next >= 10'(HD + HF) && x_next <= 10'(HD + HF + HR - 1)) ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= (y_next >= 10'(VD + VF) && y_next <= 10'(VD + VF + VR - 1)) ? SYNC_ACT : ~SYNC_ACT;
            frame_start <= x_wrap && y_wrap;
         end
      end
   end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: random-length runs and async resets on two shrunken rasters, checked against a pixel-index model.
`timescale 1ns/1ps
module tb_vga_sync_gen;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   int vectors = 0;
   int miscompares = 0;
   longint n;
   logic       a_tick, a_vid, a_hs, a_vs, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_tick, b_vid, b_hs, b_vs, b_fs;
   logic [9:0] b_x, b_y;
   vga_sync_gen #(.HD(16), .HF(2), .HR(3), .HB(4), .VD(6), .VF(1), .VR(2), .VB(3), .DIV(3), .SYNC_ACT(1'b0)) dut_a (
      .clk(clk), .reset(reset), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
      .video_on(a_vid), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
   );
   vga_sync_gen #(.HD(10), .HF(3), .HR(4), .HB(3), .VD(5), .VF(2), .VR(3), .VB(1), .DIV(1), .SYNC_ACT(1'b1)) dut_b (
      .clk(clk), .reset(reset), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
      .video_on(b_vid), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
   );
   // Clock edges seen since reset release; everything else is derived from it.
   always @(posedge clk or posedge reset) begin
      if (reset) n <= 0;
      else n <= n + 1;
   end
   function automatic logic [24:0] ref_model(longint cnt, int hd, int hf, int hr, int hb,
                                             int vd, int vf, int vr, int vb, int div, bit act);
      int ht = hd + hf + hr + hb;
      int vt = vd + vf + vr + vb;
      longint p = cnt / div;
      int idx = int'(p % (ht * vt));
      int x = idx % ht;
      int y = idx / ht;
      bit started = p > 0;
      logic tick = (cnt % div) == div - 1;
      logic vid = started && x < hd && y < vd;
      logic hs = (x >= hd + hf && x < hd + hf + hr) ? act : ~act;
      logic vs = (y >= vd + vf && y < vd + vf + vr) ? act : ~act;
      logic fs = started && idx == 0;
      return {tick, 10'(x), 10'(y), vid, hs, vs, fs};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at n=%0d: got %0d, expected %0d", tag, n, got, exp);
      end
   endtask
   task automatic check_all();
      logic [24:0] ea, eb;
      ea = ref_model(n, 16, 2, 3, 4, 6, 1, 2, 3, 3, 1'b0);
      eb = ref_model(n, 10, 3, 4, 3, 5, 2, 3, 1, 1, 1'b1);
      check("a_p_tick", 32'(a_tick), 32'(ea[24]));
      check("a_pixel_x", 32'(a_x), 32'(ea[23:14]));
      check("a_pixel_y", 32'(a_y), 32'(ea[13:4]));
      check("a_video_on", 32'(a_vid), 32'(ea[3]));
      check("a_hsync", 32'(a_hs), 32'(ea[2]));
      check("a_vsync", 32'(a_vs), 32'(ea[1]));
      check("a_frame_start", 32'(a_fs), 32'(ea[0]));
      check("b_p_tick", 32'(b_tick), 32'(eb[24]));
      check("b_pixel_x", 32'(b_x), 32'(eb[23:14]));
      check("b_pixel_y", 32'(b_y), 32'(eb[13:4]));
      check("b_video_on", 32'(b_vid), 32'(eb[3]));
      check("b_hsync", 32'(b_hs), 32'(eb[2]));
      check("b_vsync", 32'(b_vs), 32'(eb[1]));
      check("b_frame_start", 32'(b_fs), 32'(eb[0]));
   endtask
   always @(negedge clk) check_all();
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      // Long first run covers several full frames of both rasters.
      repeat (2800) @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #($urandom_range(1, 4));
         reset = 1'b1;
         #1 check_all();
         repeat ($urandom_range(1, 3)) @(posedge clk);
         @(negedge clk) reset = 1'b0;
         repeat ($urandom_range(20, 1200)) @(posedge clk);
      end
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing source for the VGA text path. Generates pixel_x, pixel_y, video_on, hsync and vsync for the 640x480@60 Hz mode.
- Downstream pixel generators (font ROM lookup, colour mux) consume pixel_x/pixel_y/video_on. The board connector consumes hsync/vsync.
- Runs on the system clock and divides it internally to the pixel rate. p_tick is exported so consumers can qualify their pipelines.

Parameters:
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch (pixels)
- HR, 96, horizontal sync width (pixels)
- HB, 48, horizontal back porch (pixels)
- VD, 480, vertical display lines
- VF, 10, vertical front porch (lines)
- VR, 2, vertical sync width (lines)
- VB, 33, vertical back porch (lines)
- DIV, 4, system clocks per pixel (>=1; 100 MHz -> 25 MHz)
- SYNC_ACT, 0, active level of hsync/vsync

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active-high
- p_tick  out  1  high for one clk per pixel; counters advance at the edge ending this cycle
- pixel_x  out  10  current column, 0..HT-1 (HT=HD+HF+HR+HB=800)
- pixel_y  out  10  current line, 0..VT-1 (VT=VD+VF+VR+VB=525)
- video_on  out  1  1 when pixel_x<HD and pixel_y<VD
- hsync  out  1  horizontal sync, SYNC_ACT while asserted
- vsync  out  1  vertical sync, SYNC_ACT while asserted
- frame_start  out  1  high for the whole pixel period of (0,0) following a frame wrap

Behaviour:
- Reset (async assert, sync release):
  - div_cnt=0, pixel_x=0, pixel_y=0, video_on=0, frame_start=0.
  - hsync=vsync=~SYNC_ACT.
  - p_tick=0, except p_tick=1 when DIV=1.
- Divider:
  - div_cnt counts 0..DIV-1 on every clk and wraps to 0.
  - p_tick = (div_cnt==DIV-1). It is combinational from the register.
  - For DIV=1, p_tick is constantly 1 outside reset.
- Horizontal counter:
  - On a clk edge with p_tick=1, pixel_x increments.
  - At HT-1 it wraps to 0.
- Vertical counter:
  - pixel_y increments only on the edge where pixel_x wraps.
  - At VT-1, coincident with the pixel_x wrap, it wraps to 0.
- Registered outputs: video_on, hsync, vsync and frame_start are loaded on the same edge as the counters, from the next-state counter values. They never skew relative to pixel_x/pixel_y.
- Decode rules:
  - video_on = (x_next<HD)&&(y_next<VD).
  - hsync = SYNC_ACT iff HD+HF <= x_next <= HD+HF+HR-1, i.e. 656..751.
  - vsync = SYNC_ACT iff VD+VF <= y_next <= VD+VF+VR-1, i.e. 490..491.
  - frame_start = 1 iff the edge wraps (HT-1,VT-1) -> (0,0). It clears at the next advancing edge.
- Boundaries:
  - After reset, video_on stays 0 until the first advancing edge. Pixel (0,0) of the first frame is therefore blanked; this is accepted.
  - frame_start is never asserted for the post-reset (0,0).
  - Reset mid-frame immediately forces the reset values. No partial sync pulse persists.
- Widths: counters are 10-bit. HT and VT must be <=1024, checked by elaboration assertion. There is no other arithmetic.
- Timing: line period = HT*DIV clks (3200 at default). Frame period = VT*HT*DIV clks (1,680,000 at default).

Test Plan:
- Hold reset, then release → outputs at reset values. The first p_tick occurs on the 4th clk after release. pixel_x reads 1 after that edge, and video_on=1.
- Default params, free-run 2 frames → hsync low for exactly 384 clks, with the falling edge when pixel_x becomes 656. Line period is 3200 clks.
- Free-run → vsync low for exactly 6400 clks, starting when pixel_y becomes 490. Frame period is 1,680,000 clks. frame_start fires once per frame, 4 clks wide, aligned with pixel (0,0).
- Count p_tick cycles with video_on=1 over one full frame after the first frame_start → exactly 307,200 (640x480). video_on=0 at pixel_x=640 and at pixel_y=480.
- Assert reset while pixel_y=490 (vsync active), then release → vsync returns inactive asynchronously, and counters restart from 0,0.
- DIV=1, SYNC_ACT=1 → p_tick is constant 1 and the line is 800 clks. hsync is high for 96 clks, vsync is high for 1600 clks, and the counters wrap at 799/524.
